// File: rtl/gcd_controller.sv
// GCD sequencer for the shared 16-bit datapath.
// Subtract-based; result left in R[RA], with start/done handshake and timeout.
package gcd_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_EOR = 4'h1,
    ALU_SUB = 4'h2,
    ALU_RSB = 4'h3,
    ALU_ADD = 4'h4,
    ALU_ADC = 4'h5,
    ALU_SBC = 4'h6,
    ALU_RSC = 4'h7,
    ALU_TST = 4'h8,
    ALU_TEQ = 4'h9,
    ALU_CMP = 4'hA,
    ALU_CMN = 4'hB,
    ALU_ORR = 4'hC,
    ALU_MOV = 4'hD,
    ALU_BIC = 4'hE,
    ALU_MVN = 4'hF
  } alu_ctl_t;

  typedef logic [4:0] shift_amt_t;
  typedef logic [3:0] reg_sel_t;
endpackage

module gcd_controller
  import gcd_pkg::*;
#(
  parameter reg_sel_t    RA       = 4'd0,
  parameter reg_sel_t    RB       = 4'd1,
  parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output alu_ctl_t    op,
  output shift_amt_t  sh,
  output reg_sel_t    d,
  output reg_sel_t    n,
  output reg_sel_t    m,
  output logic        dw,
  input  logic        cn,
  input  logic        cz,
  input  logic        cc,
  input  logic        cv,
  output logic        done,
  output logic        err,
  output logic [15:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHKB,
    S_CHKA,
    S_CMP,
    S_SUBA,
    S_SUBB,
    S_COPY,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] iter_q, iter_d;
  logic        err_q, err_d;
  logic        unused_flags;

  assign unused_flags = cn ^ cv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      iter_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // iter saturates rather than wrapping
  function automatic logic [15:0] iter_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = 16'd0;
          err_d   = 1'b0;
          state_d = S_CHKB;
        end
      end
      S_CHKB: begin
        state_d = cz ? S_DONE : S_CHKA;
      end
      S_CHKA: begin
        state_d = cz ? S_COPY : S_CMP;
      end
      S_COPY: begin
        state_d = S_DONE;
      end
      S_CMP: begin
        if (cz) begin
          state_d = S_DONE;
        end else if (iter_q == MAX_ITER) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cc) begin
          state_d = S_SUBA;
        end else begin
          state_d = S_SUBB;
        end
      end
      S_SUBA: begin
        iter_d  = iter_inc(iter_q);
        state_d = S_CMP;
      end
      S_SUBB: begin
        iter_d  = iter_inc(iter_q);
        state_d = S_CMP;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    op   = ALU_AND;
    sh   = '0;
    d    = RA;
    n    = RA;
    m    = RA;
    dw   = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_CHKB: begin
        n = RB;
        m = RB;
      end
      S_CHKA: begin
      end
      S_COPY: begin
        op = ALU_ORR;
        n  = RB;
        m  = RB;
        dw = 1'b1;
      end
      S_CMP: begin
        op = ALU_SUB;
        m  = RB;
      end
      S_SUBA: begin
        op = ALU_SUB;
        m  = RB;
        dw = 1'b1;
      end
      S_SUBB: begin
        op = ALU_SUB;
        d  = RB;
        n  = RB;
        dw = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
    endcase
  end

  assign err  = err_q;
  assign iter = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller with a behavioural datapath.
// Expected results queued at start, checked at done.
module tb_gcd_controller;
  import gcd_pkg::*;

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] it;
    logic        er;
    int          cyc;
    int          dws;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  alu_ctl_t    op;
  shift_amt_t  sh;
  reg_sel_t    d, n, m;
  logic        dw;
  logic        cn, cz, cc, cv;
  logic        done, err;
  logic [15:0] iter;

  logic [15:0] regs [16];
  logic [15:0] a_v, b_v, res;
  logic        ld_en;
  reg_sel_t    ld_idx;
  logic [15:0] ld_val;
  int          dw_cnt;
  logic        bad_wr;

  exp_t sb[$];
  int   tests_run;
  int   fails;

  gcd_controller #(
    .RA(4'd0),
    .RB(4'd1),
    .MAX_ITER(16'd4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .op(op),
    .sh(sh),
    .d(d),
    .n(n),
    .m(m),
    .dw(dw),
    .cn(cn),
    .cz(cz),
    .cc(cc),
    .cv(cv),
    .done(done),
    .err(err),
    .iter(iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_v = regs[n];
    b_v = regs[m];
    res = '0;
    cc  = 1'b0;
    cv  = 1'b0;
    case (op)
      ALU_SUB: begin
        res = a_v - b_v;
        cc  = (a_v >= b_v);
        cv  = (a_v[15] != b_v[15]) &&
              (res[15] != a_v[15]);
      end
      ALU_ORR: res = a_v | b_v;
      default: res = a_v & b_v;
    endcase
    cz = (res == 16'd0);
    cn = res[15];
  end

  initial begin
    dw_cnt = 0;
    bad_wr = 1'b0;
  end

  always @(posedge clk) begin
    if (ld_en) begin
      regs[ld_idx] <= ld_val;
    end else if (dw) begin
      regs[d] <= res;
      dw_cnt  <= dw_cnt + 1;
      if (d > 4'd1) bad_wr <= 1'b1;
    end
  end

  task automatic load(input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = 4'd0;
    ld_val = a;
    @(negedge clk);
    ld_idx = 4'd1;
    ld_val = b;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic run_gcd(input logic [15:0] a,
                         input logic [15:0] b,
                         input bit ld,
                         input bit hold,
                         input exp_t e,
                         input string nm);
    exp_t x;
    int c;
    int dw0;
    if (ld) load(a, b);
    sb.push_back(e);
    dw0 = dw_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    c = 0;
    while (!done && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    x = sb.pop_front();
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s done: timeout after %0d cycles", nm, c);
      return;
    end
    tests_run++;
    if (c != x.cyc) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, c, x.cyc);
    end
    tests_run++;
    if (regs[0] !== x.r0 || regs[1] !== x.r1) begin
      fails++;
      $display("FAIL %s regs: got R0=%0d R1=%0d want R0=%0d R1=%0d",
               nm, regs[0], regs[1], x.r0, x.r1);
    end
    tests_run++;
    if (iter !== x.it || err !== x.er) begin
      fails++;
      $display("FAIL %s iter/err: got %0d/%0b want %0d/%0b",
               nm, iter, err, x.it, x.er);
    end
    tests_run++;
    if (dw_cnt - dw0 != x.dws) begin
      fails++;
      $display("FAIL %s dw pulses: got %0d want %0d",
               nm, dw_cnt - dw0, x.dws);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s idle: done got %0b want 0", nm, done);
      end
    end
  endtask

  task automatic check_idle_outs(input string nm);
    tests_run++;
    if (done !== 1'b0 || err !== 1'b0 || iter !== 16'd0 ||
        dw !== 1'b0 || op !== ALU_AND || sh !== '0 ||
        d !== 4'd0 || n !== 4'd0 || m !== 4'd0) begin
      fails++;
      $display("FAIL %s: got done=%0b err=%0b iter=%0d dw=%0b op=%0d d/n/m=%0d/%0d/%0d want all reset",
               nm, done, err, iter, dw, op, d, n, m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_val = '0;
    #2;
    check_idle_outs("reset_async");
    @(posedge clk);
    #1;
    check_idle_outs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    e = '{r0:16'd6, r1:16'd6, it:16'd2,
          er:1'b0, cyc:7, dws:2};
    run_gcd(16'd12, 16'd18, 1, 0, e, "gcd_12_18");
  endtask

  task automatic test_b_zero();
    exp_t e;
    e = '{r0:16'd7, r1:16'd0, it:16'd0,
          er:1'b0, cyc:1, dws:0};
    run_gcd(16'd7, 16'd0, 1, 0, e, "b_zero");
  endtask

  task automatic test_a_zero();
    exp_t e;
    e = '{r0:16'd5, r1:16'd5, it:16'd0,
          er:1'b0, cyc:3, dws:1};
    run_gcd(16'd0, 16'd5, 1, 0, e, "a_zero");
  endtask

  task automatic test_timeout();
    exp_t e;
    int dw0;
    e = '{r0:16'd65531, r1:16'd1, it:16'd4,
          er:1'b1, cyc:11, dws:4};
    run_gcd(16'd65535, 16'd1, 1, 1, e, "timeout");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b1 || err !== 1'b1) begin
        fails++;
        $display("FAIL hold_done[%0d]: got done=%0b err=%0b want 1/1",
                 i, done, err);
      end
    end
    dw0 = dw_cnt;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL drop_start: done got %0b want 0", done);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || dw_cnt != dw0) begin
      fails++;
      $display("FAIL stay_idle: done=%0b dw pulses=%0d want 0/0",
               done, dw_cnt - dw0);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int c;
    bit hit;
    load(16'd9, 16'd6);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 0;
    c = 0;
    while (!hit && c < 50) begin
      @(posedge clk);
      #1;
      c++;
      if (dw === 1'b1 && d === 4'd1) hit = 1;
    end
    tests_run++;
    if (!hit) begin
      fails++;
      $display("FAIL subb_seen: got none in %0d cycles want SUBB", c);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outs("mid_reset");
    tests_run++;
    if (regs[0] !== 16'd3 || regs[1] !== 16'd6) begin
      fails++;
      $display("FAIL mid_reset_regs: got R0=%0d R1=%0d want 3/6",
               regs[0], regs[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = '{r0:16'd3, r1:16'd3, it:16'd1,
          er:1'b0, cyc:5, dws:1};
    run_gcd(16'd3, 16'd6, 1, 0, e, "after_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = '{r0:16'd40000, r1:16'd40000, it:16'd0,
          er:1'b0, cyc:3, dws:0};
    run_gcd(16'd40000, 16'd40000, 1, 0, e, "equal_1");
    run_gcd(16'd40000, 16'd40000, 0, 0, e, "equal_2");
  endtask

  task automatic test_write_range();
    tests_run++;
    if (bad_wr !== 1'b0) begin
      fails++;
      $display("FAIL write_range: got bad write=%0b want 0", bad_wr);
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_b_zero();
    test_a_zero();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_write_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Moore-style sequencer that drives the shared ARM-ish 16-bit datapath to compute the unsigned GCD of R[RA] and R[RB] by repeated subtraction, leaving the result in R[RA]. It replaces the fixed-function controller on the datapath's control/flag ports and adds a start/done handshake, an iteration counter and a timeout error flag.

## Interface
- RA, 0: register index holding operand a and, on completion, the result.
- RB, 1: register index holding operand b; clobbered during operation.
- MAX_ITER, 16'hFFFF: subtract-step limit. Reaching it ends the run with err=1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately.
- start  in  1  level request, sampled only in IDLE.
- op  out  alu_ctl_t  ALU operation to datapath.
- sh  out  shift_amt_t  Rm shift amount; always 0.
- d, n, m  out  reg_sel_t  destination and source register selects.
- dw  out  1  register-file write enable; R[d] <= out at the rising edge when 1.
- cn, cz, cc, cv  in  1 each  datapath flags, combinational from the current cycle's op/n/m. cc=1 on SUB means unsigned R[n] >= R[m].
- done  out  1  result valid in R[RA].
- err  out  1  run ended by timeout; valid while done=1.
- iter  out  16  subtract steps taken in the current or last run.

## Operation
- States: IDLE, CHKB, CHKA, CMP, SUBA, SUBB, COPY, DONE.
- Default controls in every state: op=ALU_AND, sh=0, d=n=m=RA, dw=0. Only the overrides below differ.
- IDLE: start=1 -> clear iter and err, go to CHKB. Otherwise stay.
- CHKB: AND n=m=RB. cz=1 (b==0) -> DONE, since R[RA] already holds gcd(a,0)=a. Otherwise go to CHKA.
- CHKA: AND n=m=RA. cz=1 -> COPY. Otherwise go to CMP.
- COPY: op=ALU_ORR, d=RA, n=m=RB, dw=1 (R[RA] <= b). Go to DONE.
- CMP: op=ALU_SUB, n=RA, m=RB, dw=0.
  - cz=1 -> DONE.
  - Else iter==MAX_ITER -> set err=1 and go to DONE.
  - Else cc=1 -> SUBA; otherwise -> SUBB.
- SUBA: op=ALU_SUB, d=RA, n=RA, m=RB, dw=1. Increment iter, go to CMP.
- SUBB: op=ALU_SUB, d=RB, n=RB, m=RA, dw=1. Increment iter, go to CMP.
- DONE: done=1; err and iter hold. start=0 -> IDLE; start still 1 -> stay in DONE. No new run starts until start has been observed low.
- iter is 16-bit and saturates at 16'hFFFF; it never wraps. The timeout check precedes the cc decision.
- Flags cn and cv are ignored.
- The controller never writes a register outside RA/RB and never drives dw=1 outside COPY, SUBA and SUBB.

## Timing
- Reset values: state IDLE, done=0, err=0, iter=0, dw=0, op=ALU_AND, sh=0, d=n=m=RA.
- Outputs are a function of state only. Branch decisions use same-cycle flags and take effect at the next edge.
- Edge k is the edge that samples start=1 in IDLE. Then CHKB follows edge k, CHKA follows k+1, CMP follows k+2.
- Each subtract iteration costs 2 cycles (CMP + SUBx).
- Equal nonzero operands: done=1 after edge k+3.
- b==0: done=1 after edge k+1.
- a==0, b!=0: done=1 after edge k+3; R[RA] is written at edge k+3.
- Reset asserted mid-run, including during a SUBx write cycle: outputs return to reset values asynchronously and dw drops at once. R[RA]/R[RB] hold whatever the last completed edge wrote.
- start toggling outside IDLE/DONE is ignored.

## Test plan
- R0=12, R1=18, start pulse -> sequence SUBB (R1=6), SUBA (R0=6); done=1 after edge k+7; R0=6, iter=2, err=0.
- R0=7, R1=0 -> done after edge k+1; R0=7, iter=0, no dw pulse.
- R0=0, R1=5 -> single dw pulse in COPY; done after edge k+3; R0=5.
- R0=65535, R1=1, MAX_ITER=4 -> err=1, iter=4, done=1, R0=65531. Then hold start=1 for 3 cycles: stays in DONE. Drop start: IDLE.
- R0=9, R1=6; drive reset low during the first SUBB -> done=0, dw=0, iter=0 immediately. Release reset, R1 reloaded to 6, restart -> R0=3, done=1.
- R0=R1=40000 -> done after edge k+3, iter=0, R0=40000; back-to-back second run after start low/high gives the same result.
